cc_serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor (A - B), LSB first, one bit per clock through a registered borrow.

---
 rtl/cc_serial_subtractor_pkg.sv | 12 +
 rtl/cc_fullsubtractor.sv | 13 +
 rtl/cc_serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_cc_serial_subtractor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package cc_serial_subtractor_pkg;

   localparam int DATAWIDTH_BUS_DEF = 8;

   typedef enum logic [1:0] {
      STATE_IDLE  = 2'd0,
      STATE_SHIFT = 2'd1,
      STATE_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/cc_fullsubtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module cc_fullsubtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/cc_serial_subtractor.sv
// Bit-serial N-bit subtractor (A - B), LSB first, one bit per clock through a registered borrow.
// Optional signed-overflow output enabled by defining CC_SERIALSUB_OVERFLOW_EN.
module cc_serial_subtractor
   import cc_serial_subtractor_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF
) (
   input  logic                     CC_SERIALSUB_CLOCK_50,
   input  logic                     CC_SERIALSUB_RESET_InLow,
   input  logic                     CC_SERIALSUB_start_In,
   input  logic [DATAWIDTH_BUS-1:0] CC_SERIALSUB_a_In,
   input  logic [DATAWIDTH_BUS-1:0] CC_SERIALSUB_b_In,
   output logic                     CC_SERIALSUB_busy_Out,
   output logic                     CC_SERIALSUB_done_Out,
   output logic [DATAWIDTH_BUS-1:0] CC_SERIALSUB_diff_Out,
   output logic [1:0]               CC_SERIALSUB_dbg_state_Out,
   output logic                     CC_SERIALSUB_borrow_Out
`ifdef CC_SERIALSUB_OVERFLOW_EN
   ,
   output logic                     CC_SERIALSUB_ovf_Out
`endif
);

   localparam int CW = $clog2(DATAWIDTH_BUS) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATAWIDTH_BUS - 1);

   state_t                   r_state;
   state_t                   w_next_state;
   logic                     w_load;
   logic                     w_shift;
   logic                     w_finish;

   logic [DATAWIDTH_BUS-1:0] r_a_sh;
   logic [DATAWIDTH_BUS-1:0] r_b_sh;
   logic [DATAWIDTH_BUS-1:0] r_res;
   logic                     r_borrow;
   logic [CW-1:0]            r_cnt;

   logic [DATAWIDTH_BUS-1:0] r_diff;
   logic                     r_borrow_out;
   logic                     r_done;

   logic                     w_d;
   logic                     w_bout;

   cc_fullsubtractor u_fullsub (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   always_ff @(posedge CC_SERIALSUB_CLOCK_50 or negedge CC_SERIALSUB_RESET_InLow) begin
      if (!CC_SERIALSUB_RESET_InLow) begin
         r_state <= STATE_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         STATE_IDLE: begin
            if (CC_SERIALSUB_start_In) begin
               w_load       = 1'b1;
               w_next_state = STATE_SHIFT;
            end
         end
         STATE_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_next_state = STATE_DONE;
            end
         end
         STATE_DONE: begin
            w_finish     = 1'b1;
            w_next_state = STATE_IDLE;
         end
         default: begin
            w_next_state = STATE_IDLE;
         end
      endcase
   end

   // Each difference bit enters at the MSB, so after N shifts bit 0 has reached position 0.
   always_ff @(posedge CC_SERIALSUB_CLOCK_50 or negedge CC_SERIALSUB_RESET_InLow) begin
      if (!CC_SERIALSUB_RESET_InLow) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a_sh   <= CC_SERIALSUB_a_In;
         r_b_sh   <= CC_SERIALSUB_b_In;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_shift) begin
         r_a_sh   <= r_a_sh >> 1;
         r_b_sh   <= r_b_sh >> 1;
         r_res    <= {w_d, r_res[DATAWIDTH_BUS-1:1]};
         r_borrow <= w_bout;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge CC_SERIALSUB_CLOCK_50 or negedge CC_SERIALSUB_RESET_InLow) begin
      if (!CC_SERIALSUB_RESET_InLow) begin
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_finish) begin
            r_diff       <= r_res;
            r_borrow_out <= r_borrow;
         end
      end
   end

`ifdef CC_SERIALSUB_OVERFLOW_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   // Operand MSBs are shifted out during the operation, so keep copies for the overflow test.
   always_ff @(posedge CC_SERIALSUB_CLOCK_50 or negedge CC_SERIALSUB_RESET_InLow) begin
      if (!CC_SERIALSUB_RESET_InLow) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_load) begin
            r_a_msb <= CC_SERIALSUB_a_In[DATAWIDTH_BUS-1];
            r_b_msb <= CC_SERIALSUB_b_In[DATAWIDTH_BUS-1];
         end
         if (w_finish) begin
            r_ovf <= (r_a_msb != r_b_msb) && (r_res[DATAWIDTH_BUS-1] != r_a_msb);
         end
      end
   end

   assign CC_SERIALSUB_ovf_Out = r_ovf;
`endif

   assign CC_SERIALSUB_busy_Out      = (r_state != STATE_IDLE);
   assign CC_SERIALSUB_done_Out      = r_done;
   assign CC_SERIALSUB_diff_Out      = r_diff;
   assign CC_SERIALSUB_borrow_Out    = r_borrow_out;
   assign CC_SERIALSUB_dbg_state_Out = r_state;

endmodule

// File: tb/tb_cc_serial_subtractor.sv
// Self-checking bench for cc_serial_subtractor: driver tasks push expected results, a monitor checks them.
module tb_cc_serial_subtractor;

   localparam int N = 8;
   localparam int LAT = N + 1;

   typedef struct {
      logic [N-1:0] diff;
      logic         borrow;
      logic         ovf;
      int           acc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic [1:0]   dbg_state;
   logic         borrow;
`ifdef CC_SERIALSUB_OVERFLOW_EN
   logic         ovf;
`endif

   exp_t         exp_q[$];
   int           checks;
   int           failures;
   int           cyc;
   logic         prev_done;
   logic [N-1:0] last_diff;
   logic         last_borrow;

   cc_serial_subtractor #(.DATAWIDTH_BUS(N)) dut (
      .CC_SERIALSUB_CLOCK_50      (clk),
      .CC_SERIALSUB_RESET_InLow   (rst_n),
      .CC_SERIALSUB_start_In      (start),
      .CC_SERIALSUB_a_In          (a_in),
      .CC_SERIALSUB_b_In          (b_in),
      .CC_SERIALSUB_busy_Out      (busy),
      .CC_SERIALSUB_done_Out      (done),
      .CC_SERIALSUB_diff_Out      (diff),
      .CC_SERIALSUB_dbg_state_Out (dbg_state),
      .CC_SERIALSUB_borrow_Out    (borrow)
`ifdef CC_SERIALSUB_OVERFLOW_EN
      ,
      .CC_SERIALSUB_ovf_Out       (ovf)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: plain integer arithmetic
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc);
      exp_t e;
      int   sa;
      int   sb;
      int   sd;
      sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
      sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
      sd = sa - sb;
      e.diff   = N'((int'(a) - int'(b)) & ((1 << N) - 1));
      e.borrow = (int'(a) < int'(b));
      e.ovf    = (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
      e.acc    = acc;
      return e;
   endfunction

   // driver tasks
   task automatic wait_idle();
      int guard;
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      @(negedge clk);
      wait_idle();
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      if (push) exp_q.push_back(model(a, b, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      a_in = N'($urandom);
      b_in = N'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_diff"}, 32'(diff), 32'd0);
      chk({tag, "_borrow"}, 32'(borrow), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_state"}, 32'(dbg_state), 32'd0);
`ifdef CC_SERIALSUB_OVERFLOW_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         chk("done_single_pulse", 32'(prev_done), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("diff", 32'(diff), 32'(e.diff));
            chk("borrow", 32'(borrow), 32'(e.borrow));
            chk("latency", 32'(cyc - e.acc), 32'(LAT));
`ifdef CC_SERIALSUB_OVERFLOW_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            last_diff   = e.diff;
            last_borrow = e.borrow;
         end
      end
      prev_done = rst_n && done;
   end

   logic [N-1:0] dir_a[8];
   logic [N-1:0] dir_b[8];

   initial begin
      checks      = 0;
      failures    = 0;
      prev_done   = 1'b0;
      last_diff   = '0;
      last_borrow = 1'b0;
      rst_n       = 1'b0;
      start       = 1'b0;
      a_in        = '0;
      b_in        = '0;
      dir_a = '{8'h05, 8'h03, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hAA};
      dir_b = '{8'h03, 8'h05, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'h80, 8'h55};

      repeat (3) @(negedge clk);
      chk_cleared("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed vectors including full borrow ripple and overflow corners
      foreach (dir_a[i]) begin
         op(dir_a[i], dir_b[i], 1'b1);
         drain();
      end

      // result holds while idle
      repeat (6) @(negedge clk);
      chk("hold_diff", 32'(diff), 32'(last_diff));
      chk("hold_borrow", 32'(borrow), 32'(last_borrow));

      // start re-asserted mid-operation with new operands is ignored
      op(8'h05, 8'h03, 1'b1);
      @(negedge clk);
      a_in  = 8'h40;
      b_in  = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      // start held high: back-to-back ops, second accepted on first idle cycle
      a_in  = 8'h10;
      b_in  = 8'h20;
      start = 1'b1;
      exp_q.push_back(model(8'h10, 8'h20, cyc + 1));
      @(negedge clk);
      a_in = 8'h9C;
      b_in = 8'h1D;
      exp_q.push_back(model(8'h9C, 8'h1D, cyc + N + 2));
      repeat (N + 2) @(negedge clk);
      start = 1'b0;
      drain();

      // reset mid-shift: drop operation, clear outputs, no done
      op(8'h33, 8'h44, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_cleared("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 4) @(negedge clk);
      chk("no_done_after_reset", 32'(exp_q.size()), 32'd0);
      op(8'h21, 8'h12, 1'b1);
      drain();

      // randomized operations with random idle gaps
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] ra;
         logic [N-1:0] rb;
         ra = N'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : N'($urandom);
         op(ra, rb, 1'b1);
         if ($urandom_range(0, 1) == 1) drain();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
